// File: rtl/matrix_slot_allocator_pkg.sv
// Shared constants, types and helpers for the matrix slot allocator.
// Optional grant statistics are built in when ALLOC_STATS_EN is defined.
package matrix_slot_allocator_pkg;

    localparam int MAX_DIM     = 5;
    localparam int MAX_PER_DIM = 2;
    localparam int NUM_SHAPES  = MAX_DIM * MAX_DIM;
    localparam int NUM_SLOTS   = NUM_SHAPES * MAX_PER_DIM;
    localparam int ID_W        = 7;
    localparam int DIM_W       = 4;
    localparam int STAT_W      = 8;
    localparam int SLOT_W      = (MAX_PER_DIM > 1) ? $clog2(MAX_PER_DIM) : 1;
    localparam int SHAPE_W     = $clog2(NUM_SHAPES);

    typedef logic [ID_W-1:0]    id_t;
    typedef logic [DIM_W-1:0]   dim_t;
    typedef logic [SLOT_W-1:0]  slot_t;
    typedef logic [SHAPE_W-1:0] shape_idx_t;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    function automatic logic shape_legal(input dim_t m, input dim_t n);
        return (int'(m) >= 1) && (int'(m) <= MAX_DIM) &&
               (int'(n) >= 1) && (int'(n) <= MAX_DIM);
    endfunction

    function automatic shape_idx_t shape_index(input dim_t m, input dim_t n);
        return shape_idx_t'((int'(m) - 1) * MAX_DIM + (int'(n) - 1));
    endfunction

endpackage

// File: rtl/matrix_slot_allocator_if.sv
// Allocate / free / clear / query bus of the matrix slot allocator.
// Statistics signals exist only when ALLOC_STATS_EN is defined.
interface matrix_slot_allocator_if;
    import matrix_slot_allocator_pkg::*;

    logic alloc_req;
    dim_t alloc_m;
    dim_t alloc_n;
    logic alloc_valid;
    id_t  alloc_id_out;
    logic alloc_overwrite;
    logic alloc_err;
    logic free_req;
    id_t  free_id;
    logic clr_req;
    logic busy;
    id_t  query_id;
    logic query_valid;
    dim_t query_m;
    dim_t query_n;
`ifdef ALLOC_STATS_EN
    logic [STAT_W-1:0] stat_alloc_cnt;
    logic [STAT_W-1:0] stat_ovw_cnt;
`endif

    modport slave (
`ifdef ALLOC_STATS_EN
        output stat_alloc_cnt,
        output stat_ovw_cnt,
`endif
        input  alloc_req,
        input  alloc_m,
        input  alloc_n,
        output alloc_valid,
        output alloc_id_out,
        output alloc_overwrite,
        output alloc_err,
        input  free_req,
        input  free_id,
        input  clr_req,
        output busy,
        input  query_id,
        output query_valid,
        output query_m,
        output query_n
    );

    modport master (
`ifdef ALLOC_STATS_EN
        input  stat_alloc_cnt,
        input  stat_ovw_cnt,
`endif
        output alloc_req,
        output alloc_m,
        output alloc_n,
        input  alloc_valid,
        input  alloc_id_out,
        input  alloc_overwrite,
        input  alloc_err,
        output free_req,
        output free_id,
        output clr_req,
        input  busy,
        output query_id,
        input  query_valid,
        input  query_m,
        input  query_n
    );

endinterface

// File: rtl/matrix_slot_allocator_slot_id_codec.sv
// Pure combinational mapping between (m, n, slot) and a matrix ID.
module slot_id_codec
    import matrix_slot_allocator_pkg::*;
(
    input  dim_t  i_m,
    input  dim_t  i_n,
    input  slot_t i_slot,
    output id_t   o_id,
    input  id_t   i_id,
    output dim_t  o_m,
    output dim_t  o_n,
    output slot_t o_slot,
    output logic  o_in_range
);

    int w_enc;
    int w_shape;

    always_comb begin
        w_enc = ((int'(i_m) - 1) * MAX_DIM + (int'(i_n) - 1)) * MAX_PER_DIM
              + int'(i_slot);
        o_id  = id_t'(w_enc);
    end

    always_comb begin
        o_in_range = (int'(i_id) < NUM_SLOTS);
        w_shape    = int'(i_id) / MAX_PER_DIM;
        o_slot     = '0;
        o_m        = '0;
        o_n        = '0;
        if (o_in_range) begin
            o_slot = slot_t'(int'(i_id) % MAX_PER_DIM);
            o_m    = dim_t'(w_shape / MAX_DIM + 1);
            o_n    = dim_t'(w_shape % MAX_DIM + 1);
        end
    end

endmodule

// File: rtl/matrix_slot_allocator.sv
// Matrix storage-slot allocator: grant, free, sequenced clear and query.
// Define ALLOC_STATS_EN to add saturating grant/overwrite counters.
module matrix_slot_allocator
    import matrix_slot_allocator_pkg::*;
(
    input logic                    clk,
    input logic                    rst,
    matrix_slot_allocator_if.slave bus
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_SLOTS-1:0] r_valid;
    slot_t                r_ptr [NUM_SHAPES];
    id_t                  r_sweep;
    logic                 r_pend_vld;
    dim_t                 r_pend_m;
    dim_t                 r_pend_n;
    logic                 r_alloc_valid;
    id_t                  r_alloc_id;
    logic                 r_alloc_ovw;
    logic                 r_alloc_err;
    logic                 r_query_valid;
    dim_t                 r_query_m;
    dim_t                 r_query_n;

    logic                   w_idle;
    logic                   w_sweep_last;
    dim_t                   w_req_m;
    dim_t                   w_req_n;
    logic                   w_serve;
    logic                   w_legal;
    logic                   w_grant;
    shape_idx_t             w_shape;
    logic [MAX_PER_DIM-1:0] w_live;
    logic                   w_has_free;
    slot_t                  w_free_slot;
    slot_t                  w_ptr_cur;
    slot_t                  w_slot;
    id_t                    w_grant_id;
    logic                   w_free_in_range;
    logic                   w_free_do;
    logic [NUM_SLOTS-1:0]   w_set_mask;
    logic [NUM_SLOTS-1:0]   w_clr_mask;
    dim_t                   w_query_m;
    dim_t                   w_query_n;
    logic                   w_query_in_range;
    logic                   w_q_live;
    dim_t                   w_unused_free_m;
    dim_t                   w_unused_free_n;
    slot_t                  w_unused_free_slot;
    id_t                    w_unused_query_id;
    slot_t                  w_unused_query_slot;

    assign w_idle       = (r_state == S_IDLE);
    assign w_sweep_last = (r_sweep == id_t'(NUM_SLOTS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.clr_req) w_state_nxt = S_CLEAR;
            S_CLEAR: if (w_sweep_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (r_state == S_CLEAR);
    end

    // A request parked during the sweep takes precedence over the live bus.
    assign w_req_m = r_pend_vld ? r_pend_m : bus.alloc_m;
    assign w_req_n = r_pend_vld ? r_pend_n : bus.alloc_n;
    assign w_serve = w_idle && (r_pend_vld || bus.alloc_req);
    assign w_legal = shape_legal(w_req_m, w_req_n);
    assign w_grant = w_serve && w_legal;
    assign w_shape = shape_index(w_req_m, w_req_n);
    assign w_live  = MAX_PER_DIM'(r_valid >> (int'(w_shape) * MAX_PER_DIM));

    always_comb begin
        w_has_free  = 1'b0;
        w_free_slot = '0;
        for (int s = MAX_PER_DIM - 1; s >= 0; s--) begin
            if (!w_live[s]) begin
                w_has_free  = 1'b1;
                w_free_slot = slot_t'(s);
            end
        end
    end

    assign w_ptr_cur = r_ptr[w_shape];
    assign w_slot    = w_has_free ? w_free_slot : w_ptr_cur;

    slot_id_codec u_grant_codec (
        .i_m        (w_req_m),
        .i_n        (w_req_n),
        .i_slot     (w_slot),
        .o_id       (w_grant_id),
        .i_id       (bus.free_id),
        .o_m        (w_unused_free_m),
        .o_n        (w_unused_free_n),
        .o_slot     (w_unused_free_slot),
        .o_in_range (w_free_in_range)
    );

    slot_id_codec u_query_codec (
        .i_m        ('0),
        .i_n        ('0),
        .i_slot     ('0),
        .o_id       (w_unused_query_id),
        .i_id       (bus.query_id),
        .o_m        (w_query_m),
        .o_n        (w_query_n),
        .o_slot     (w_unused_query_slot),
        .o_in_range (w_query_in_range)
    );

    assign w_free_do  = w_idle && bus.free_req && w_free_in_range;
    assign w_set_mask = NUM_SLOTS'(w_grant) << w_grant_id;

    always_comb begin
        w_clr_mask = '0;
        if (w_free_do) w_clr_mask = NUM_SLOTS'(1) << bus.free_id;
        if (!w_idle)   w_clr_mask = NUM_SLOTS'(1) << r_sweep;
    end

    // Set after clear: an alloc and a free of the same ID leave it live.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_valid <= '0;
        else     r_valid <= (r_valid & ~w_clr_mask) | w_set_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SHAPES; i++) r_ptr[i] <= '0;
        end else if (!w_idle && w_sweep_last) begin
            for (int i = 0; i < NUM_SHAPES; i++) r_ptr[i] <= '0;
        end else if (w_grant && !w_has_free) begin
            r_ptr[w_shape] <= (int'(w_ptr_cur) == MAX_PER_DIM - 1) ?
                              '0 : w_ptr_cur + slot_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sweep <= '0;
        else     r_sweep <= w_idle ? '0 : r_sweep + id_t'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_vld <= 1'b0;
            r_pend_m   <= '0;
            r_pend_n   <= '0;
        end else if (w_idle) begin
            if (r_pend_vld) begin
                r_pend_vld <= bus.alloc_req;
                if (bus.alloc_req) begin
                    r_pend_m <= bus.alloc_m;
                    r_pend_n <= bus.alloc_n;
                end
            end
        end else if (bus.alloc_req && !r_pend_vld) begin
            r_pend_vld <= 1'b1;
            r_pend_m   <= bus.alloc_m;
            r_pend_n   <= bus.alloc_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alloc_valid <= 1'b0;
            r_alloc_id    <= '0;
            r_alloc_ovw   <= 1'b0;
            r_alloc_err   <= 1'b0;
        end else begin
            r_alloc_valid <= w_grant;
            r_alloc_id    <= w_grant ? w_grant_id : '0;
            r_alloc_ovw   <= w_grant && !w_has_free;
            r_alloc_err   <= (w_serve && !w_legal) ||
                             (!w_idle && bus.alloc_req && r_pend_vld);
        end
    end

    assign w_q_live = w_query_in_range &&
                      |(r_valid & (NUM_SLOTS'(1) << bus.query_id));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_query_valid <= 1'b0;
            r_query_m     <= '0;
            r_query_n     <= '0;
        end else begin
            r_query_valid <= w_q_live;
            r_query_m     <= w_q_live ? w_query_m : '0;
            r_query_n     <= w_q_live ? w_query_n : '0;
        end
    end

    assign bus.alloc_valid     = r_alloc_valid;
    assign bus.alloc_id_out    = r_alloc_id;
    assign bus.alloc_overwrite = r_alloc_ovw;
    assign bus.alloc_err       = r_alloc_err;
    assign bus.query_valid     = r_query_valid;
    assign bus.query_m         = r_query_m;
    assign bus.query_n         = r_query_n;

`ifdef ALLOC_STATS_EN
    logic [STAT_W-1:0] r_stat_alloc;
    logic [STAT_W-1:0] r_stat_ovw;
    logic              w_clr_accept;

    assign w_clr_accept = w_idle && bus.clr_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_alloc <= '0;
            r_stat_ovw   <= '0;
        end else if (w_clr_accept) begin
            r_stat_alloc <= '0;
            r_stat_ovw   <= '0;
        end else if (w_grant) begin
            if (r_stat_alloc != '1)
                r_stat_alloc <= r_stat_alloc + STAT_W'(1);
            if (!w_has_free && r_stat_ovw != '1)
                r_stat_ovw <= r_stat_ovw + STAT_W'(1);
        end
    end

    assign bus.stat_alloc_cnt = r_stat_alloc;
    assign bus.stat_ovw_cnt   = r_stat_ovw;
`endif

endmodule
